lsu_ctrl: RTL

Load/store unit that consumes the decoder's memory controls (MEM_READ, MEM_WRITE, BYTE_SEL, SIGN) and executes the access on the single-port data-memory bus. It aligns write data and generates byte strobes, then extracts and sign- or zero-extends load data. It stalls the pipeline until the bus acknowledges, and flags misaligned or timed-out accesses. It sits between the execute stage (ALU address, rs2 data) and the register-file write-back mux (RF_SEL = 2'b10 source).

---
 rtl/lsu_ctrl.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store unit bridging decoder memory controls to a single-port data bus
//
// Ports:
//   CLK, RST                   clock (rising edge), synchronous active-high reset
//   MEM_READ, MEM_WRITE        access request from the decoder (write wins when both set)
//   BYTE_SEL, SIGN             access size (00 byte, 01 half, 1x word) and load extension
//   ADDR, WDATA                byte address and store data from execute
//   STALL                      holds the pipeline while an access is in flight
//   RDATA, RDATA_VALID         extended load result and its one-cycle completion pulse
//   MISALIGNED, BUS_ERR        one-cycle pulses for rejected and timed-out accesses
//   BUS_REQ .. BUS_WDATA       request side of the data-memory bus
//   BUS_ACK, BUS_RDATA         response side of the data-memory bus

module lsu_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MEM_READ,
  input  logic        MEM_WRITE,
  input  logic [1:0]  BYTE_SEL,
  input  logic        SIGN,
  input  logic [31:0] ADDR,
  input  logic [31:0] WDATA,
  output logic        STALL,
  output logic [31:0] RDATA,
  output logic        RDATA_VALID,
  output logic        MISALIGNED,
  output logic        BUS_ERR,
  output logic        BUS_REQ,
  output logic        BUS_WE,
  output logic [31:0] BUS_ADDR,
  output logic [3:0]  BUS_WSTRB,
  output logic [31:0] BUS_WDATA,
  input  logic        BUS_ACK,
  input  logic [31:0] BUS_RDATA
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_wstrb_q, bus_wstrb_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic        is_byte_q, is_byte_d;
  logic        is_half_q, is_half_d;
  logic        sign_q, sign_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rdata_valid_q, rdata_valid_d;
  logic        misaligned_q, misaligned_d;
  logic        bus_err_q, bus_err_d;

  logic        req_in;
  logic        size_byte;
  logic        size_half;
  logic        misal_in;
  logic [3:0]  strb_in;
  logic [31:0] wdata_in;
  logic [31:0] rd_shifted;
  logic [31:0] load_ext;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  // Request decode and store-side alignment from the live inputs.
  always_comb begin
    req_in    = MEM_READ | MEM_WRITE;
    size_byte = (BYTE_SEL == 2'b00);
    size_half = (BYTE_SEL == 2'b01);
    misal_in  = size_half ? ADDR[0] : (!size_byte && (ADDR[1:0] != 2'b00));
    strb_in   = 4'b1111;
    wdata_in  = WDATA;
    if (size_byte) begin
      strb_in  = 4'b0001 << ADDR[1:0];
      wdata_in = {4{WDATA[7:0]}};
    end else if (size_half) begin
      strb_in  = ADDR[1] ? 4'b1100 : 4'b0011;
      wdata_in = {2{WDATA[15:0]}};
    end
  end

  // Load-side lane extraction uses the latched address and size, not the live inputs.
  always_comb begin
    rd_shifted = BUS_RDATA >> {addr_lo_q, 3'b000};
    if (is_byte_q) begin
      load_ext = {{24{sign_q & rd_shifted[7]}}, rd_shifted[7:0]};
    end else if (is_half_q) begin
      load_ext = {{16{sign_q & rd_shifted[15]}}, rd_shifted[15:0]};
    end else begin
      load_ext = BUS_RDATA;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bus_req_d     = bus_req_q;
    bus_we_d      = bus_we_q;
    bus_addr_d    = bus_addr_q;
    bus_wstrb_d   = bus_wstrb_q;
    bus_wdata_d   = bus_wdata_q;
    is_byte_d     = is_byte_q;
    is_half_d     = is_half_q;
    sign_d        = sign_q;
    addr_lo_d     = addr_lo_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    misaligned_d  = 1'b0;
    bus_err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_in) begin
          bus_we_d    = MEM_WRITE;
          bus_addr_d  = {ADDR[31:2], 2'b00};
          bus_wstrb_d = MEM_WRITE ? strb_in : 4'b0000;
          bus_wdata_d = wdata_in;
          is_byte_d   = size_byte;
          is_half_d   = size_half;
          sign_d      = SIGN;
          addr_lo_d   = ADDR[1:0];
          cnt_d       = 8'd0;
          if (misal_in) begin
            // Rejected without touching the bus; the pulse lands in DONE.
            state_d      = DONE;
            misaligned_d = 1'b1;
          end else begin
            state_d   = BUSY;
            bus_req_d = 1'b1;
          end
        end
      end
      BUSY: begin
        if (BUS_ACK) begin
          state_d   = DONE;
          bus_req_d = 1'b0;
          cnt_d     = 8'd0;
          if (!bus_we_q) begin
            rdata_d       = load_ext;
            rdata_valid_d = 1'b1;
          end
        end else if (cnt_q == TIMEOUT_LAST) begin
          // cnt_q counts unanswered request cycles already spent, so this is the last one.
          state_d   = DONE;
          bus_req_d = 1'b0;
          cnt_d     = 8'd0;
          bus_err_d = 1'b1;
          rdata_d   = 32'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        // Decoder controls are still asserted here; ignoring them prevents a replay.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= IDLE;
      cnt_q         <= 8'd0;
      bus_req_q     <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_addr_q    <= 32'd0;
      bus_wstrb_q   <= 4'b0000;
      bus_wdata_q   <= 32'd0;
      is_byte_q     <= 1'b0;
      is_half_q     <= 1'b0;
      sign_q        <= 1'b0;
      addr_lo_q     <= 2'b00;
      rdata_q       <= 32'd0;
      rdata_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
      bus_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bus_req_q     <= bus_req_d;
      bus_we_q      <= bus_we_d;
      bus_addr_q    <= bus_addr_d;
      bus_wstrb_q   <= bus_wstrb_d;
      bus_wdata_q   <= bus_wdata_d;
      is_byte_q     <= is_byte_d;
      is_half_q     <= is_half_d;
      sign_q        <= sign_d;
      addr_lo_q     <= addr_lo_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      misaligned_q  <= misaligned_d;
      bus_err_q     <= bus_err_d;
    end
  end

  // STALL must rise in the request cycle itself, so it cannot come from a flop.
  assign STALL       = !RST && (((state_q == IDLE) && req_in) || (state_q == BUSY));
  assign RDATA       = rdata_q;
  assign RDATA_VALID = rdata_valid_q;
  assign MISALIGNED  = misaligned_q;
  assign BUS_ERR     = bus_err_q;
  assign BUS_REQ     = bus_req_q;
  assign BUS_WE      = bus_we_q;
  assign BUS_ADDR    = bus_addr_q;
  assign BUS_WSTRB   = bus_wstrb_q;
  assign BUS_WDATA   = bus_wdata_q;

endmodule
